rv_lsu: RTL and testbench

Load/store unit for the RV32IM core: the initiator side of the data memory interface. It accepts one load or store at a time from the execute stage and drives `data_req_o`/`data_we_o`/`data_be_o`/`data_addr_o`/`data_wdata_o` toward the data RAM, holding them until `data_rvalid_i`. It then returns sign- or zero-extended load data to writeback. It sits between the execute stage and the data RAM, and stalls the pipeline through `lsu_ready_o`.

---
 rtl/rv_pkg.sv | 4 +
 rtl/rv_lsu_if.sv | 20 ++
 rtl/rv_lsu.sv | 165 ++++++++++++++++
 tb/tb_rv_lsu.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants for the RV32IM core.
package rv_pkg;
   localparam int XLEN = 32;
endpackage

// File: rtl/rv_lsu_if.sv
// rv_lsu_if: data memory bus between the load/store unit (master) and the data RAM (slave).
interface rv_lsu_if;
   logic                         data_req_o;
   logic                         data_we_o;
   logic [rv_pkg::XLEN/8-1:0]    data_be_o;
   logic [rv_pkg::XLEN-1:0]      data_addr_o;
   logic [rv_pkg::XLEN-1:0]      data_wdata_o;
   logic                         data_rvalid_i;
   logic [rv_pkg::XLEN-1:0]      data_rdata_i;

   modport master (
      output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      input  data_rvalid_i, data_rdata_i
   );

   modport slave (
      input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      output data_rvalid_i, data_rdata_i
   );
endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit, initiator side of the data memory bus.
// One load or store in flight; the bus outputs are registered at accept and held
// until the memory responds. Load data is lane-extracted and sign/zero-extended.
// Optional feature: define RV_LSU_MISALIGN_EN to complete misaligned half/word
// requests locally (flagged on lsu_misalign_o) instead of issuing them.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing in flight, ready for a request
// WAIT    | request on the bus, waiting for data_rvalid_i
// RELEASE | completion pulse; data_req_o low so the memory resets its response path
module rv_lsu (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     lsu_req_i,
   input  logic                     lsu_we_i,
   input  logic [1:0]               lsu_size_i,
   input  logic                     lsu_unsigned_i,
   input  logic [rv_pkg::XLEN-1:0]  lsu_addr_i,
   input  logic [rv_pkg::XLEN-1:0]  lsu_wdata_i,
   output logic                     lsu_ready_o,
   output logic                     lsu_rvalid_o,
   output logic [rv_pkg::XLEN-1:0]  lsu_rdata_o,
   output logic                     lsu_misalign_o,
   rv_lsu_if.master                 data_if
);
   localparam int XLEN = rv_pkg::XLEN;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              r_state;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [1:0]          r_off;
   logic                r_req;
   logic                r_we;
   logic [XLEN/8-1:0]   r_be;
   logic [XLEN-1:0]     r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic                r_rvalid;
   logic                r_misalign;
   logic [XLEN-1:0]     r_rdata;

   logic [XLEN/8-1:0]   w_be;
   logic [XLEN-1:0]     w_wdata;
   logic                w_misalign;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [XLEN-1:0]     w_ext;

`ifdef RV_LSU_MISALIGN_EN
   assign w_misalign = ((lsu_size_i == 2'b01) && lsu_addr_i[0]) ||
                       (lsu_size_i[1] && (lsu_addr_i[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // Byte enables and lane-replicated store data for the incoming request.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = lsu_wdata_i;
      if (lsu_we_i) begin
         case (lsu_size_i)
            2'b00: begin
               w_be    = 4'b0001 << lsu_addr_i[1:0];
               w_wdata = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
               w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = lsu_wdata_i;
            end
         endcase
      end
   end

   assign w_byte = data_if.data_rdata_i[{r_off, 3'b000} +: 8];
   assign w_half = data_if.data_rdata_i[{r_off[1], 4'b0000} +: 16];

   // Lane extraction and extension of the returned word using the latched request shape.
   always_comb begin
      w_ext = data_if.data_rdata_i;
      case (r_size)
         2'b00:   w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ext = data_if.data_rdata_i;
      endcase
   end

   // Transaction FSM with all bus and completion outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_off      <= 2'b00;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_be       <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rvalid   <= 1'b0;
         r_misalign <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_rvalid   <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            S_IDLE, S_RELEASE: begin
               if (lsu_req_i) begin
                  if (w_misalign) begin
                     // Never reaches memory: complete next cycle with the flag set.
                     r_state    <= S_RELEASE;
                     r_rvalid   <= 1'b1;
                     r_misalign <= 1'b1;
                     r_rdata    <= '0;
                  end else begin
                     r_state    <= S_WAIT;
                     r_req      <= 1'b1;
                     r_we       <= lsu_we_i;
                     r_be       <= w_be;
                     r_addr     <= {lsu_addr_i[XLEN-1:2], 2'b00};
                     r_wdata    <= w_wdata;
                     r_size     <= lsu_size_i;
                     r_unsigned <= lsu_unsigned_i;
                     r_off      <= lsu_addr_i[1:0];
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (data_if.data_rvalid_i) begin
                  r_state  <= S_RELEASE;
                  r_req    <= 1'b0;
                  r_rvalid <= 1'b1;
                  r_rdata  <= r_we ? '0 : w_ext;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign lsu_ready_o          = (r_state == S_IDLE) || (r_state == S_RELEASE);
   assign lsu_rvalid_o         = r_rvalid;
   assign lsu_rdata_o          = r_rdata;
   assign lsu_misalign_o       = r_misalign;
   assign data_if.data_req_o   = r_req;
   assign data_if.data_we_o    = r_we;
   assign data_if.data_be_o    = r_be;
   assign data_if.data_addr_o  = r_addr;
   assign data_if.data_wdata_o = r_wdata;

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: self-checking bench for rv_lsu with a latency-programmable RAM
// responder and a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_rv_lsu;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [1:0]  lsu_size_i;
   logic        lsu_unsigned_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ready_o;
   logic        lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_misalign_o;

   int checks = 0;
   int errors = 0;

   rv_lsu_if bus ();

   rv_lsu dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lsu_req_i      (lsu_req_i),
      .lsu_we_i       (lsu_we_i),
      .lsu_size_i     (lsu_size_i),
      .lsu_unsigned_i (lsu_unsigned_i),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_ready_o    (lsu_ready_o),
      .lsu_rvalid_o   (lsu_rvalid_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .lsu_misalign_o (lsu_misalign_o),
      .data_if        (bus)
   );

   always #5 clk_i = ~clk_i;

   // RAM responder: word array; data_rvalid_i in the (L+2)-th cycle of request high.
   logic [31:0] ram [16];
   logic [7:0]  ref_b [64];
   int          mem_lat = 3;
   bit          inject = 1'b0;
   int          req_cnt = 0;

   initial begin
      bus.data_rvalid_i = 1'b0;
      bus.data_rdata_i  = 32'h0;
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         req_cnt = 0;
         bus.data_rvalid_i = 1'b0;
      end else if (bus.data_req_o) begin
         req_cnt++;
         if (req_cnt == mem_lat + 2) begin
            if (bus.data_we_o)
               for (int b = 0; b < 4; b++)
                  if (bus.data_be_o[b])
                     ram[bus.data_addr_o[5:2]][8*b +: 8] = bus.data_wdata_o[8*b +: 8];
            bus.data_rdata_i  = ram[bus.data_addr_o[5:2]];
            bus.data_rvalid_i = 1'b1;
            req_cnt = 0;
         end else begin
            bus.data_rvalid_i = 1'b0;
         end
      end else begin
         req_cnt = 0;
         bus.data_rvalid_i = inject;
         bus.data_rdata_i  = 32'hDEAD_BEEF;
      end
   end

   // Reference model: byte-addressed memory and access-shape rules.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] exp_be(input bit we, input logic [1:0] sz, input logic [31:0] a);
      int n;
      int base;
      n = nbytes(sz);
      base = int'(a[1:0]) & ~(n - 1);
      if (!we) return 4'hF;
      return 4'(((1 << n) - 1) << base);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] v;
      int n;
      n = nbytes(sz);
      v = 32'h0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   function automatic bit exp_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef RV_LSU_MISALIGN_EN
      int n;
      n = nbytes(sz);
      return ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
      int n;
      int base;
      logic [31:0] v;
      logic [31:0] mask;
      n = nbytes(sz);
      base = int'(a[5:0]) & ~(n - 1);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[base + i]) << (8 * i));
      if (!uns && n < 4) begin
         mask = (32'h1 << (8 * n)) - 32'h1;
         if (v[8*n - 1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int n;
      int base;
      n = nbytes(sz);
      base = int'(a[5:0]) & ~(n - 1);
      for (int i = 0; i < n; i++) ref_b[base + i] = wd[8*i +: 8];
   endtask

   task automatic init_word(input int idx, input logic [31:0] v);
      ram[idx] = v;
      for (int i = 0; i < 4; i++) ref_b[4*idx + i] = v[8*i +: 8];
   endtask

   // Issue one request (called at a negedge), report what the bus and completion looked like.
   task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        output int cyc, output logic [31:0] rd, output logic mis,
                        output logic [3:0] be1, output logic [31:0] ad1,
                        output logic [31:0] wd1, output logic req1, output int req_hi);
      mem_lat = lat;
      for (int k = 0; k < 50; k++) begin
         if (lsu_ready_o) break;
         @(negedge clk_i);
      end
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_unsigned_i = uns;
      lsu_addr_i = a; lsu_wdata_i = wd;
      @(posedge clk_i);
      #1 lsu_req_i = 1'b0;
      cyc = -1; rd = 32'hx; mis = 1'bx; req_hi = 0;
      be1 = 4'hx; ad1 = 32'hx; wd1 = 32'hx; req1 = 1'bx;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk_i);
         if (c == 1) begin
            be1 = bus.data_be_o; ad1 = bus.data_addr_o;
            wd1 = bus.data_wdata_o; req1 = bus.data_req_o;
         end
         if (bus.data_req_o) req_hi++;
         if (lsu_rvalid_o) begin
            cyc = c; rd = lsu_rdata_o; mis = lsu_misalign_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
      lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", lsu_ready_o); end
      checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", lsu_rvalid_o); end
      checks++; if (lsu_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", lsu_misalign_o); end
      checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", lsu_rdata_o); end
      checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.data_req_o); end
      checks++; if ({bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o} !== 69'h0) begin
         errors++; $display("FAIL reset_bus: got we=%b be=%h addr=%h wdata=%h expected all 0",
                            bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_lb_negative();
      int cyc; int rh; logic [31:0] rd; logic mis; logic [3:0] be1; logic [31:0] ad1; logic [31:0] wd1; logic req1;
      init_word(4, 32'h80FF_7F01);
      do_op(1'b0, 2'b00, 1'b0, 32'h0000_1012, 32'h0, 3, cyc, rd, mis, be1, ad1, wd1, req1, rh);
      checks++; if (be1 !== 4'hF) begin errors++; $display("FAIL lb_be: got %h expected f", be1); end
      checks++; if (ad1 !== 32'h0000_1010) begin errors++; $display("FAIL lb_addr: got %h expected 00001010", ad1); end
      checks++; if (cyc !== 6) begin errors++; $display("FAIL lb_latency: got %0d expected 6", cyc); end
      checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_rdata: got %h expected ffffffff", rd); end
      repeat (2) @(negedge clk_i);
      checks++; if (lsu_rdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_hold: got %h expected ffffffff", lsu_rdata_o); end
      do_op(1'b0, 2'b00, 1'b1, 32'h0000_1012, 32'h0, 3, cyc, rd, mis, be1, ad1, wd1, req1, rh);
      checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000ff", rd); end
   endtask

   task automatic test_sh_upper();
      int cyc; int rh; logic [31:0] rd; logic mis; logic [3:0] be1; logic [31:0] ad1; logic [31:0] wd1; logic req1;
      do_op(1'b1, 2'b01, 1'b0, 32'h0000_1012, 32'h1234_ABCD, 3, cyc, rd, mis, be1, ad1, wd1, req1, rh);
      ref_store(2'b01, 32'h0000_1012, 32'h1234_ABCD);
      checks++; if (be1 !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", be1); end
      checks++; if (wd1 !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", wd1); end
      checks++; if (rh !== 5) begin errors++; $display("FAIL sh_req_held: got %0d cycles expected 5", rh); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h expected 0", rd); end
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, 2, cyc, rd, mis, be1, ad1, wd1, req1, rh);
      checks++; if (rd !== 32'hABCD_7F01) begin errors++; $display("FAIL sh_readback: got %h expected abcd7f01", rd); end
   endtask

   task automatic test_back_to_back();
      int cyc; int rh; logic [31:0] rd; logic mis; logic [3:0] be1; logic [31:0] ad1; logic [31:0] wd1; logic req1;
      logic [31:0] v;
      v = $urandom;
      do_op(1'b1, 2'b10, 1'b0, 32'h0000_0020, v, $urandom_range(0, 3), cyc, rd, mis, be1, ad1, wd1, req1, rh);
      ref_store(2'b10, 32'h0000_0020, v);
      checks++; if (bus.data_req_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
         errors++; $display("FAIL b2b_release: got req=%b ready=%b expected req=0 ready=1", bus.data_req_o, lsu_ready_o);
      end
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, $urandom_range(0, 3), cyc, rd, mis, be1, ad1, wd1, req1, rh);
      checks++; if (req1 !== 1'b1) begin errors++; $display("FAIL b2b_req_next: got %b expected 1", req1); end
      checks++; if (rd !== v) begin errors++; $display("FAIL b2b_readback: got %h expected %h", rd, v); end
   endtask

   task automatic test_stall();
      bit bad;
      @(negedge clk_i);
      mem_lat = 2;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_unsigned_i = 1'b0;
      lsu_addr_i = 32'h0000_2224; lsu_wdata_i = 32'h0;
      @(posedge clk_i);
      #1 lsu_addr_i = 32'h0000_3338; lsu_we_i = 1'b1;
      bad = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_i);
         if (bus.data_addr_o !== 32'h0000_2224 || lsu_ready_o !== 1'b0 || bus.data_we_o !== 1'b0) begin
            bad = 1'b1;
            $display("FAIL stall_hold: cycle %0d got addr=%h ready=%b we=%b expected addr=00002224 ready=0 we=0",
                     c, bus.data_addr_o, lsu_ready_o, bus.data_we_o);
         end
      end
      checks++; if (bad) errors++;
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (lsu_rvalid_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
         errors++; $display("FAIL stall_complete: got rvalid=%b ready=%b expected 1 1", lsu_rvalid_o, lsu_ready_o);
      end
      checks++; if (lsu_rdata_o !== ref_load(2'b10, 1'b0, 32'h0000_2224)) begin
         errors++; $display("FAIL stall_rdata: got %h expected %h", lsu_rdata_o, ref_load(2'b10, 1'b0, 32'h0000_2224));
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid_wait();
      bit seen;
      mem_lat = 3;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h0000_0008;
      @(posedge clk_i);
      #1 lsu_req_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks++; if (bus.data_req_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
         errors++; $display("FAIL rst_wait: got req=%b ready=%b expected req=0 ready=1", bus.data_req_o, lsu_ready_o);
      end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (lsu_rvalid_o) seen = 1'b1;
         @(negedge clk_i);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rvalid: got pulse=%b expected 0", seen); end
   endtask

   task automatic test_rvalid_ignored();
      bit seen;
      seen = 1'b0;
      inject = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         if (lsu_rvalid_o || !lsu_ready_o || bus.data_req_o) seen = 1'b1;
      end
      inject = 1'b0;
      repeat (2) @(negedge clk_i);
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stray_rvalid: got reaction=%b expected 0", seen); end
   endtask

   task automatic test_misalign();
      int cyc; int rh; logic [31:0] rd; logic mis; logic [3:0] be1; logic [31:0] ad1; logic [31:0] wd1; logic req1;
      init_word(8, 32'h5A5A_1234);
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0021, 32'h0, 3, cyc, rd, mis, be1, ad1, wd1, req1, rh);
`ifdef RV_LSU_MISALIGN_EN
      checks++; if (cyc !== 1) begin errors++; $display("FAIL mis_latency: got %0d expected 1", cyc); end
      checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", mis); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", rd); end
      checks++; if (rh !== 0) begin errors++; $display("FAIL mis_no_req: got %0d req cycles expected 0", rh); end
`else
      checks++; if (cyc !== 6) begin errors++; $display("FAIL mis_latency: got %0d expected 6", cyc); end
      checks++; if (mis !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b expected 0", mis); end
      checks++; if (rd !== 32'h5A5A_1234) begin errors++; $display("FAIL mis_rdata: got %h expected 5a5a1234", rd); end
      checks++; if (ad1 !== 32'h0000_0020) begin errors++; $display("FAIL mis_addr: got %h expected 00000020", ad1); end
`endif
   endtask

   task automatic test_random();
      int cyc; int rh; logic [31:0] rd; logic mis; logic [3:0] be1; logic [31:0] ad1; logic [31:0] wd1; logic req1;
      bit we; bit uns; logic [1:0] sz; logic [31:0] a; logic [31:0] wd; int lat; bit m;
      logic [31:0] erd;
      for (int it = 0; it < 40; it++) begin
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         a   = {$urandom_range(0, 255), 6'($urandom_range(0, 63))};
         wd  = $urandom;
         lat = $urandom_range(0, 3);
         m   = exp_mis(sz, a);
         erd = (we || m) ? 32'h0 : ref_load(sz, uns, a);
         do_op(we, sz, uns, a, wd, lat, cyc, rd, mis, be1, ad1, wd1, req1, rh);
         if (we && !m) ref_store(sz, a, wd);
         checks++; if (cyc !== (m ? 1 : lat + 3)) begin
            errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, cyc, m ? 1 : lat + 3);
         end
         checks++; if (rd !== erd || mis !== m) begin
            errors++; $display("FAIL rnd_result[%0d]: got rdata=%h mis=%b expected rdata=%h mis=%b", it, rd, mis, erd, m);
         end
         if (!m) begin
            checks++; if (be1 !== exp_be(we, sz, a) || ad1 !== {a[31:2], 2'b00} || rh !== lat + 2) begin
               errors++; $display("FAIL rnd_bus[%0d]: got be=%h addr=%h req_cycles=%0d expected be=%h addr=%h req_cycles=%0d",
                                  it, be1, ad1, rh, exp_be(we, sz, a), {a[31:2], 2'b00}, lat + 2);
            end
            if (we) begin
               checks++; if (wd1 !== exp_wdata(sz, wd)) begin
                  errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", it, wd1, exp_wdata(sz, wd));
               end
            end
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 32'h0;
      for (int i = 0; i < 64; i++) ref_b[i] = 8'h0;
      test_reset();
      test_lb_negative();
      test_sh_upper();
      test_back_to_back();
      test_stall();
      test_reset_mid_wait();
      test_rvalid_ignored();
      test_misalign();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
